iob_cache_back_end_iob: RTL

//  Back-end IOb master of the cache: the initiator side of the IOb bus whose

---
 rtl/iob_cache_back_end_iob_pkg.sv | 25 ++
 rtl/iob_cache_back_end_iob_if.sv | 25 ++
 rtl/iob_cache_back_end_iob_reg.sv | 23 ++
 rtl/iob_cache_back_end_iob.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/iob_cache_back_end_iob_pkg.sv
// Shared types and derived-width helpers for the cache back-end IOb master.
package iob_cache_back_end_iob_pkg;

    // Back-end controller states: idle, draining one write-buffer entry, filling a line.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    localparam int DEF_ADDR_W     = 24;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_WORD_OFF_W = 3;

    // Number of byte-offset bits inside one data word.
    function automatic int calc_nbytes_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Width of a cache line address (byte address minus word and byte offsets).
    function automatic int calc_line_w(input int addr_w, input int data_w, input int word_off_w);
        return addr_w - word_off_w - calc_nbytes_w(data_w);
    endfunction

endpackage

// File: rtl/iob_cache_back_end_iob_if.sv
// IOb bus between the cache back-end (master) and external memory (slave).
interface iob_cache_back_end_iob_if
    import iob_cache_back_end_iob_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic                  valid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (
        output valid, addr, wdata, wstrb,
        input  rvalid, rdata, ready
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output rvalid, rdata, ready
    );
endinterface

// File: rtl/iob_cache_back_end_iob_reg.sv
// Register with asynchronous reset, global clock enable and local enable.
module iob_cache_back_end_iob_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic         cke_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // Load only when both enables are high; reset wins at any time.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            q_o <= RST_VAL;
        end else if (cke_i && en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/iob_cache_back_end_iob.sv
// Cache back-end IOb master: drains write-through entries as single IOb
// writes and fills cache lines with pipelined IOb word reads.
module iob_cache_back_end_iob
    import iob_cache_back_end_iob_pkg::*;
#(
    parameter int  ADDR_W     = DEF_ADDR_W,
    parameter int  DATA_W     = DEF_DATA_W,
    parameter int  WORD_OFF_W = DEF_WORD_OFF_W,
    localparam int NBYTES_W   = calc_nbytes_w(DATA_W),
    localparam int LINE_W     = calc_line_w(ADDR_W, DATA_W, WORD_OFF_W)
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       cke_i,
    // write-through buffer head
    input  logic                       write_req_i,
    input  logic [ADDR_W-NBYTES_W-1:0] write_addr_i,
    input  logic [DATA_W-1:0]          write_wdata_i,
    input  logic [DATA_W/8-1:0]        write_wstrb_i,
    output logic                       write_ack_o,
    // line replacement
    input  logic                       replace_req_i,
    input  logic [LINE_W-1:0]          replace_addr_i,
    output logic                       replace_o,
    // line memory write port
    output logic                       read_valid_o,
    output logic [WORD_OFF_W-1:0]      read_addr_o,
    output logic [DATA_W-1:0]          read_rdata_o,
    // external memory bus
    iob_cache_back_end_iob_if.master   iob
);

    localparam int CNT_REQ = 0;
    localparam int CNT_RSP = 1;
    localparam logic [WORD_OFF_W:0] CNT_ONE = (WORD_OFF_W+1)'(1);

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            state_raw_q;

    // cnt_q[CNT_REQ] counts accepted read requests, cnt_q[CNT_RSP] counts
    // returned words. The extra MSB of the request counter marks "all sent".
    logic [WORD_OFF_W:0]   cnt_q [2];
    logic [WORD_OFF_W:0]   cnt_d [2];

    logic                  iob_valid;
    logic [ADDR_W-1:0]     iob_addr;
    logic [DATA_W-1:0]     iob_wdata;
    logic [DATA_W/8-1:0]   iob_wstrb;
    logic                  last_rsp;

    iob_cache_back_end_iob_reg #(
        .W       (2),
        .RST_VAL (ST_IDLE)
    ) u_state_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .en_i   (1'b1),
        .d_i    (state_d),
        .q_o    (state_raw_q)
    );

    assign state_q = state_t'(state_raw_q);

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        iob_cache_back_end_iob_reg #(
            .W       (WORD_OFF_W + 1),
            .RST_VAL ('0)
        ) u_cnt_reg (
            .clk_i  (clk_i),
            .arst_i (arst_i),
            .cke_i  (cke_i),
            .en_i   (1'b1),
            .d_i    (cnt_d[gi]),
            .q_o    (cnt_q[gi])
        );
    end

    assign last_rsp = (cnt_q[CNT_RSP][WORD_OFF_W-1:0] == {WORD_OFF_W{1'b1}});

    // Next-state, counter updates and all bus/line outputs, decoded from the state.
    always_comb begin
        state_d          = state_q;
        cnt_d[CNT_REQ]   = cnt_q[CNT_REQ];
        cnt_d[CNT_RSP]   = cnt_q[CNT_RSP];
        iob_valid        = 1'b0;
        iob_addr         = '0;
        iob_wdata        = '0;
        iob_wstrb        = '0;
        write_ack_o      = 1'b0;
        read_valid_o     = 1'b0;
        read_addr_o      = '0;
        read_rdata_o     = '0;

        case (state_q)
            ST_IDLE: begin
                // Pending writes go out before a fill so memory never lags the cache.
                if (write_req_i) begin
                    state_d = ST_WRITE;
                end else if (replace_req_i) begin
                    state_d = ST_READ;
                end
            end

            ST_WRITE: begin
                iob_valid = 1'b1;
                iob_addr  = ADDR_W'(write_addr_i) << NBYTES_W;
                iob_wdata = write_wdata_i;
                iob_wstrb = write_wstrb_i;
                if (iob.ready) begin
                    // Pop only when the FSM actually advances, so a frozen
                    // controller never loses a buffer entry.
                    write_ack_o = cke_i;
                    state_d     = ST_IDLE;
                end
            end

            ST_READ: begin
                iob_valid = ~cnt_q[CNT_REQ][WORD_OFF_W];
                iob_addr  = ADDR_W'({replace_addr_i, cnt_q[CNT_REQ][WORD_OFF_W-1:0]}) << NBYTES_W;
                if (iob_valid && iob.ready) begin
                    cnt_d[CNT_REQ] = cnt_q[CNT_REQ] + CNT_ONE;
                end
                if (iob.rvalid) begin
                    read_valid_o   = 1'b1;
                    read_addr_o    = cnt_q[CNT_RSP][WORD_OFF_W-1:0];
                    read_rdata_o   = iob.rdata;
                    cnt_d[CNT_RSP] = cnt_q[CNT_RSP] + CNT_ONE;
                    if (last_rsp) begin
                        state_d        = ST_IDLE;
                        cnt_d[CNT_REQ] = '0;
                        cnt_d[CNT_RSP] = '0;
                    end
                end
            end

            default: begin
                state_d        = ST_IDLE;
                cnt_d[CNT_REQ] = '0;
                cnt_d[CNT_RSP] = '0;
            end
        endcase
    end

    assign replace_o = replace_req_i | (state_q == ST_READ);

    assign iob.valid = iob_valid;
    assign iob.addr  = iob_addr;
    assign iob.wdata = iob_wdata;
    assign iob.wstrb = iob_wstrb;

endmodule
